// File: rtl/commonlib_demuxn_stream_pkg.sv
// Shared types and helpers for the commonlib stream blocks.
//   sel_width(n)   : select width for an n-lane fan-out, never less than 1
//   CNT_W_DEFAULT  : default width of saturating event counters
//   slot_state_t   : occupancy state of a one-entry pipeline slot
package commonlib_stream_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/commonlib_demuxn_stream_if.sv
// Handshake bundle of the 1-to-N stream demultiplexer.
//   in_data/in_sel/in_valid/in_ready : producer side
//   out_data/out_valid/out_ready     : N consumer lanes
// master = producer/consumer environment, slave = demux block.
interface commonlib_demuxn_stream_if #(
    parameter int N     = 5,
    parameter int WIDTH = 32
);
    import commonlib_stream_pkg::*;

    localparam int SEL_W = sel_width(N);

    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data [N-1:0];
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/commonlib_demuxn_stream_slot.sv
// One-entry valid/ready pipeline register with full throughput.
//   clk, arst_n          : clock, async active-low reset
//   in_data/valid/ready  : upstream handshake (in_ready = empty | out_ready)
//   out_data/valid/ready : downstream handshake
//
// state      | meaning
// -----------+-------------------------------------------
// SLOT_EMPTY | no word held, upstream always accepted
// SLOT_FULL  | word held and presented downstream
module commonlib_stream_slot
    import commonlib_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    slot_state_t  state;
    logic [W-1:0] data_q;

    // Refill in the same cycle the held word leaves, so no bubble.
    assign in_ready  = (state == SLOT_EMPTY) | out_ready;
    assign out_valid = (state == SLOT_FULL);
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= SLOT_EMPTY;
            data_q <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (in_valid) begin
                        state  <= SLOT_FULL;
                        data_q <= in_data;
                    end
                end
                SLOT_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            data_q <= in_data;
                        end else begin
                            state <= SLOT_EMPTY;
                        end
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/commonlib_demuxn_stream.sv
// Registered 1-to-N stream demultiplexer.
//   clk, arst_n : clock, async active-low reset
//   bus         : slave side of commonlib_demuxn_stream_if (producer + N lanes)
//   drop_cnt    : saturating count of words dropped for an out-of-range select
//   err_oob     : one-cycle pulse after an out-of-range word is dropped
// A single slot holds {sel, data}; the held word is shown only on its lane,
// other lanes read zero. Out-of-range words are consumed but never stored.
module commonlib_demuxn_stream
    import commonlib_stream_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 32,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       arst_n,
    commonlib_demuxn_stream_if.slave   bus,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       err_oob
);

    localparam int                SEL_W   = sel_width(N);
    localparam int                SLOT_W  = WIDTH + SEL_W;
    localparam logic [SEL_W:0]    N_LIM   = (SEL_W + 1)'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic              in_range;
    logic              slot_in_valid;
    logic              slot_in_ready;
    logic              slot_full;
    logic [SLOT_W-1:0] slot_q;
    logic [SEL_W-1:0]  sel_q;
    logic [WIDTH-1:0]  data_q;
    logic              lane_ready;
    logic              oob_take;

    // One extra bit so the compare also works when N is a power of two.
    assign in_range      = {1'b0, bus.in_sel} < N_LIM;
    assign slot_in_valid = bus.in_valid & in_range;
    assign bus.in_ready  = slot_in_ready;
    assign oob_take      = bus.in_valid & slot_in_ready & ~in_range;

    commonlib_stream_slot #(
        .W (SLOT_W)
    ) u_slot (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_data   ({bus.in_sel, bus.in_data}),
        .in_valid  (slot_in_valid),
        .in_ready  (slot_in_ready),
        .out_data  (slot_q),
        .out_valid (slot_full),
        .out_ready (lane_ready)
    );

    assign sel_q  = slot_q[SLOT_W-1:WIDTH];
    assign data_q = slot_q[WIDTH-1:0];

    // Lane decode; only the held lane's ready can release the slot.
    always_comb begin
        lane_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.out_valid[i] = 1'b0;
            bus.out_data[i]  = '0;
            if (sel_q == SEL_W'(i)) begin
                bus.out_valid[i] = slot_full;
                bus.out_data[i]  = data_q;
                lane_ready       = bus.out_ready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            drop_cnt <= '0;
            err_oob  <= 1'b0;
        end else begin
            err_oob <= oob_take;
            if (oob_take && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_commonlib_demuxn_stream.sv
// Directed bench for commonlib_demuxn_stream: a 5-lane/32-bit instance and a
// 1-lane/8-bit instance, scoreboard of expected lane words, producer-rule checks.
module tb_commonlib_demuxn_stream;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    commonlib_demuxn_stream_if #(.N(5), .WIDTH(32)) ia ();
    commonlib_demuxn_stream_if #(.N(1), .WIDTH(8))  ib ();

    logic [7:0] drop_a, drop_b;
    logic       err_a, err_b;

    commonlib_demuxn_stream #(.N(5), .WIDTH(32), .CNT_W(8)) dut_a (
        .clk(clk), .arst_n(arst_n), .bus(ia), .drop_cnt(drop_a), .err_oob(err_a)
    );

    commonlib_demuxn_stream #(.N(1), .WIDTH(8), .CNT_W(8)) dut_b (
        .clk(clk), .arst_n(arst_n), .bus(ib), .drop_cnt(drop_b), .err_oob(err_b)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          lane;
        logic [31:0] data;
    } exp_t;

    exp_t sbq_a[$];
    exp_t sbq_b[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard and producer rules, sampled mid-cycle while inputs are stable.
    logic        pend_a = 1'b0;
    logic [31:0] pd_a;
    logic [2:0]  ps_a;
    logic        pend_b = 1'b0;
    logic [7:0]  pd_b;
    logic        ps_b;

    always @(negedge clk) begin
        if (arst_n !== 1'b1) begin
            pend_a = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (ia.out_valid[i] && ia.out_ready[i]) begin
                    checks++;
                    assert (sbq_a.size() > 0) else begin
                        errors++;
                        $error("FAIL a_sb_unexpected lane=%0d observed=%0h expected=none", i, ia.out_data[i]);
                    end
                    if (sbq_a.size() > 0) begin
                        exp_t e;
                        e = sbq_a.pop_front();
                        chk("a_sb_lane", 64'(i), 64'(e.lane));
                        chk("a_sb_data", 64'(ia.out_data[i]), 64'(e.data));
                    end
                end
            end
            if (ia.in_valid && ia.in_ready && (ia.in_sel < 3'd5))
                sbq_a.push_back('{lane: int'(ia.in_sel), data: ia.in_data});
            if (pend_a) begin
                checks++;
                assert (ia.in_valid === 1'b1 && ia.in_data === pd_a && ia.in_sel === ps_a) else begin
                    errors++;
                    $error("FAIL a_producer_hold observed=%b/%0h/%0d expected=1/%0h/%0d",
                           ia.in_valid, ia.in_data, ia.in_sel, pd_a, ps_a);
                end
            end
            pend_a = ia.in_valid && !ia.in_ready;
            pd_a   = ia.in_data;
            ps_a   = ia.in_sel;
        end
    end

    always @(negedge clk) begin
        if (arst_n !== 1'b1) begin
            pend_b = 1'b0;
        end else begin
            if (ib.out_valid[0] && ib.out_ready[0]) begin
                checks++;
                assert (sbq_b.size() > 0) else begin
                    errors++;
                    $error("FAIL b_sb_unexpected observed=%0h expected=none", ib.out_data[0]);
                end
                if (sbq_b.size() > 0) begin
                    exp_t e;
                    e = sbq_b.pop_front();
                    chk("b_sb_data", 64'(ib.out_data[0]), 64'(e.data));
                end
            end
            if (ib.in_valid && ib.in_ready && (ib.in_sel == 1'b0))
                sbq_b.push_back('{lane: 0, data: 32'(ib.in_data)});
            if (pend_b) begin
                checks++;
                assert (ib.in_valid === 1'b1 && ib.in_data === pd_b && ib.in_sel === ps_b) else begin
                    errors++;
                    $error("FAIL b_producer_hold observed=%b/%0h/%0d expected=1/%0h/%0d",
                           ib.in_valid, ib.in_data, ib.in_sel, pd_b, ps_b);
                end
            end
            pend_b = ib.in_valid && !ib.in_ready;
            pd_b   = ib.in_data;
            ps_b   = ib.in_sel;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a word already offered.
        arst_n       = 1'b1;
        ia.in_valid  = 1'b1;
        ia.in_sel    = 3'd2;
        ia.in_data   = 32'hDEAD_BEEF;
        ia.out_ready = 5'b11111;
        ib.in_valid  = 1'b0;
        ib.in_sel    = 1'b0;
        ib.in_data   = 8'h00;
        ib.out_ready = 1'b1;
        #1 arst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(ia.out_valid), 64'h0);
        chk("rst_drop_cnt", 64'(drop_a), 64'h0);
        chk("rst_err_oob", 64'(err_a), 64'h0);
        for (int j = 0; j < 5; j++) chk("rst_out_data", 64'(ia.out_data[j]), 64'h0);
        tick();
        tick();
        arst_n = 1'b1;
        mid();
        chk("rel_in_ready", 64'(ia.in_ready), 64'h1);
        chk("rel_out_valid", 64'(ia.out_valid), 64'h0);
        tick();
        ia.in_valid = 1'b0;
        mid();
        chk("first_out_valid", 64'(ia.out_valid), 64'b00100);
        chk("first_out_data", 64'(ia.out_data[2]), 64'hDEAD_BEEF);
        for (int j = 0; j < 5; j++)
            if (j != 2) chk("first_other_lane", 64'(ia.out_data[j]), 64'h0);
        tick();

        // Back-to-back stream over all lanes.
        for (int k = 0; k < 5; k++) begin
            ia.in_valid = 1'b1;
            ia.in_sel   = 3'(k);
            ia.in_data  = 32'hB0B0_0000 + 32'(k);
            mid();
            chk("b2b_in_ready", 64'(ia.in_ready), 64'h1);
            chk("b2b_out_valid", 64'(ia.out_valid), (k == 0) ? 64'h0 : (64'h1 << (k - 1)));
            tick();
        end
        ia.in_valid = 1'b0;
        mid();
        chk("b2b_last_valid", 64'(ia.out_valid), 64'b10000);
        for (int j = 0; j < 4; j++) chk("b2b_other_lane", 64'(ia.out_data[j]), 64'h0);
        tick();

        // Backpressure on lane 3 with lane 0 ready.
        ia.out_ready = 5'b10111;
        ia.in_valid  = 1'b1;
        ia.in_sel    = 3'd3;
        ia.in_data   = 32'h3333_0003;
        mid();
        chk("bp_accept", 64'(ia.in_ready), 64'h1);
        tick();
        ia.in_sel  = 3'd0;
        ia.in_data = 32'h0000_AAAA;
        repeat (4) begin
            mid();
            chk("bp_hold_valid", 64'(ia.out_valid), 64'b01000);
            chk("bp_hold_data", 64'(ia.out_data[3]), 64'h3333_0003);
            chk("bp_in_ready", 64'(ia.in_ready), 64'h0);
            tick();
        end
        ia.out_ready = 5'b11111;
        mid();
        chk("bp_release_in_ready", 64'(ia.in_ready), 64'h1);
        tick();
        ia.in_valid = 1'b0;
        mid();
        chk("bp_next_valid", 64'(ia.out_valid), 64'b00001);
        tick();

        // Out-of-range select, then saturation of the drop counter.
        ia.in_valid = 1'b1;
        ia.in_sel   = 3'd6;
        ia.in_data  = 32'h1234_5678;
        mid();
        chk("oob_in_ready", 64'(ia.in_ready), 64'h1);
        tick();
        ia.in_valid = 1'b0;
        mid();
        chk("oob_err", 64'(err_a), 64'h1);
        chk("oob_cnt", 64'(drop_a), 64'h1);
        chk("oob_no_valid", 64'(ia.out_valid), 64'h0);
        tick();
        mid();
        chk("oob_err_clear", 64'(err_a), 64'h0);
        tick();
        ia.in_valid = 1'b1;
        for (int k = 0; k < 299; k++) begin
            ia.in_sel  = 3'(5 + (k % 3));
            ia.in_data = $urandom;
            tick();
        end
        ia.in_valid = 1'b0;
        mid();
        chk("oob_sat_cnt", 64'(drop_a), 64'd255);
        chk("oob_sat_err", 64'(err_a), 64'h1);
        tick();

        // Out-of-range word accepted while the slot drains: slot goes empty.
        ia.in_valid = 1'b1;
        ia.in_sel   = 3'd4;
        ia.in_data  = 32'h4444_0004;
        tick();
        ia.in_sel  = 3'd5;
        ia.in_data = 32'h5555_0005;
        mid();
        chk("oob_drain_in_ready", 64'(ia.in_ready), 64'h1);
        chk("oob_drain_valid", 64'(ia.out_valid), 64'b10000);
        tick();
        ia.in_valid = 1'b0;
        mid();
        chk("oob_drain_empty", 64'(ia.out_valid), 64'h0);
        chk("oob_drain_err", 64'(err_a), 64'h1);
        chk("oob_drain_cnt", 64'(drop_a), 64'd255);
        tick();

        // Reset while a word is held on lane 1.
        ia.out_ready = 5'b11101;
        ia.in_valid  = 1'b1;
        ia.in_sel    = 3'd1;
        ia.in_data   = 32'h1111_1111;
        tick();
        ia.in_valid = 1'b0;
        mid();
        chk("hold_valid", 64'(ia.out_valid), 64'b00010);
        #2 arst_n = 1'b0;
        sbq_a.delete();
        #1;
        chk("rst_async_valid", 64'(ia.out_valid), 64'h0);
        chk("rst_async_cnt", 64'(drop_a), 64'h0);
        tick();
        tick();
        arst_n       = 1'b1;
        ia.out_ready = 5'b11111;
        repeat (3) begin
            mid();
            chk("post_rst_valid", 64'(ia.out_valid), 64'h0);
            chk("post_rst_in_ready", 64'(ia.in_ready), 64'h1);
            tick();
        end

        // Single-lane instance.
        ib.in_valid = 1'b1;
        ib.in_sel   = 1'b0;
        ib.in_data  = 8'hA5;
        mid();
        chk("n1_in_ready", 64'(ib.in_ready), 64'h1);
        tick();
        ib.in_valid = 1'b0;
        mid();
        chk("n1_valid", 64'(ib.out_valid), 64'h1);
        chk("n1_data", 64'(ib.out_data[0]), 64'hA5);
        tick();
        ib.in_valid = 1'b1;
        ib.in_sel   = 1'b1;
        ib.in_data  = 8'h5A;
        mid();
        chk("n1_oob_ready", 64'(ib.in_ready), 64'h1);
        tick();
        ib.in_valid = 1'b0;
        mid();
        chk("n1_oob_err", 64'(err_b), 64'h1);
        chk("n1_oob_cnt", 64'(drop_b), 64'h1);
        chk("n1_oob_valid", 64'(ib.out_valid), 64'h0);
        tick();

        chk("sb_a_drained", 64'(sbq_a.size()), 64'h0);
        chk("sb_b_drained", 64'(sbq_b.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
